// File: rtl/mem_arbiter_if.sv
// Bundle of every signal exchanged between mem_arbiter and its surroundings.
//
//   cpu_* / dbg_*  : request ports (req, we, addr, wdata in; gnt, rdata, rvalid out)
//   mem_*          : single-port synchronous RAM side (addr, wdata, we out; rdata in)
//   cpu_stall      : CPU waiting for its grant; gates processor_enable
//   busy           : arbiter is not idle
//
// Modports:
//   slave  - the arbiter; it services requests and drives the RAM.
//   master - the environment; requesters plus the RAM model.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);

  // CPU requester
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_stall;

  // Debug requester
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;

  // RAM side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Status
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_addr, mem_wdata, mem_we,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_addr, mem_wdata, mem_we,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
//
// A CPU port and a debug port share one RAM. Each access takes two cycles:
// ACCESS (address/write data presented, gnt high) then DATA (RAM read data
// returns and is captured). Arbitration happens in IDLE and DATA, so accesses
// can run back-to-back at one per two cycles. Debug normally wins, but after
// MAX_HOLD consecutive debug grants taken while the CPU waited, the CPU wins.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-low reset; also masks gnt/mem_we combinationally
//   bus  - mem_arbiter_if.slave: requester ports, RAM port, cpu_stall, busy
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned StreakW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [StreakW-1:0] HoldMax = StreakW'(MAX_HOLD);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StData
  } state_e;

  typedef enum logic {
    OwnCpu,
    OwnDbg
  } owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [StreakW-1:0]  streak_q, streak_d;

  // Transaction captured at arbitration; the access runs from these even if
  // the requester misbehaves and drops or changes its request early.
  logic                acc_we_q, acc_we_d;
  logic [ADDR_W-1:0]   acc_addr_q, acc_addr_d;
  logic [DATA_W-1:0]   acc_wdata_q, acc_wdata_d;

  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic                dbg_rvalid_q, dbg_rvalid_d;

  logic                arb_slot;
  logic                cpu_force;
  logic                dbg_win;
  logic                cpu_win;
  logic                in_access;

  // ---------------------------------------------------------------------------
  // Arbitration decision
  // ---------------------------------------------------------------------------
  assign arb_slot  = (state_q == StIdle) || (state_q == StData);
  // Debug has held the RAM long enough while the CPU waited: CPU's turn.
  assign cpu_force = bus.cpu_req && (streak_q == HoldMax);
  assign dbg_win   = bus.dbg_req && !cpu_force;
  assign cpu_win   = bus.cpu_req && !dbg_win;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    acc_we_d     = acc_we_q;
    acc_addr_d   = acc_addr_q;
    acc_wdata_d  = acc_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;

    // A read finishing this cycle: RAM data for the ACCESS address is on
    // mem_rdata now; capture it for the owner and pulse rvalid next cycle.
    if (state_q == StData && !acc_we_q) begin
      if (owner_q == OwnCpu) begin
        cpu_rdata_d  = bus.mem_rdata;
        cpu_rvalid_d = 1'b1;
      end else begin
        dbg_rdata_d  = bus.mem_rdata;
        dbg_rvalid_d = 1'b1;
      end
    end

    if (arb_slot) begin
      if (!bus.cpu_req) begin
        streak_d = '0;
      end else if (dbg_win) begin
        streak_d = (streak_q == HoldMax) ? streak_q : streak_q + StreakW'(1);
      end else begin
        streak_d = '0;
      end
    end

    unique case (state_q)
      StIdle, StData: begin
        if (dbg_win) begin
          state_d     = StAccess;
          owner_d     = OwnDbg;
          acc_we_d    = bus.dbg_we;
          acc_addr_d  = bus.dbg_addr;
          acc_wdata_d = bus.dbg_wdata;
        end else if (cpu_win) begin
          state_d     = StAccess;
          owner_d     = OwnCpu;
          acc_we_d    = bus.cpu_we;
          acc_addr_d  = bus.cpu_addr;
          acc_wdata_d = bus.cpu_wdata;
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: state_d = StData;
      default:  state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnCpu;
      streak_q     <= '0;
      acc_we_q     <= 1'b0;
      acc_addr_q   <= '0;
      acc_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      acc_we_q     <= acc_we_d;
      acc_addr_q   <= acc_addr_d;
      acc_wdata_q  <= acc_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_access = (state_q == StAccess);

  // rst gating keeps a reset cycle that lands in ACCESS from committing a write.
  assign bus.cpu_gnt    = rst && in_access && (owner_q == OwnCpu);
  assign bus.dbg_gnt    = rst && in_access && (owner_q == OwnDbg);
  assign bus.mem_we     = rst && in_access && acc_we_q;

  // The captured transaction only changes at a grant, so these show the
  // owner's values during ACCESS and hold them otherwise.
  assign bus.mem_addr   = acc_addr_q;
  assign bus.mem_wdata  = acc_wdata_q;

  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;

  assign bus.cpu_stall  = bus.cpu_req && !bus.cpu_gnt;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural synchronous RAM sits on the
// mem_* side and hand-computed expectations are checked cycle by cycle.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic load;
  int   tests;
  int   fails;

  logic [7:0] ram [256];

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_arbiter #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .MAX_HOLD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    if (a < 8)      return 8'h60 + 8'(a);
    if (a == 'h15)  return 8'hA7;
    if (a == 'h10)  return 8'h99;
    return 8'h00;
  endfunction

  // Read-first synchronous RAM: data for the address seen at an edge is
  // available during the following cycle.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    load = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;

    // ---- reset state ----
    repeat (3) next_cycle();
    load = 1'b0;
    settle();
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_cpu_gnt", bus.cpu_gnt, 1'b0);
    chk1("rst_dbg_gnt", bus.dbg_gnt, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk8("rst_mem_addr", bus.mem_addr, 8'h00);
    chk8("rst_mem_wdata", bus.mem_wdata, 8'h00);
    chk1("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk1("rst_dbg_rvalid", bus.dbg_rvalid, 1'b0);
    chk8("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    chk8("rst_dbg_rdata", bus.dbg_rdata, 8'h00);
    next_cycle();
    rst = 1'b1;

    // ---- single CPU read of 0x15 ----
    next_cycle();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h15;
    settle();
    chk1("t1_c0_stall", bus.cpu_stall, 1'b1);
    chk1("t1_c0_gnt", bus.cpu_gnt, 1'b0);
    next_cycle(); settle();
    chk1("t1_c1_gnt", bus.cpu_gnt, 1'b1);
    chk8("t1_c1_addr", bus.mem_addr, 8'h15);
    chk1("t1_c1_we", bus.mem_we, 1'b0);
    chk1("t1_c1_stall", bus.cpu_stall, 1'b0);
    chk1("t1_c1_busy", bus.busy, 1'b1);
    next_cycle();
    bus.cpu_req = 1'b0;
    settle();
    chk1("t1_c2_gnt", bus.cpu_gnt, 1'b0);
    chk1("t1_c2_busy", bus.busy, 1'b1);
    chk1("t1_c2_rvalid", bus.cpu_rvalid, 1'b0);
    next_cycle(); settle();
    chk1("t1_c3_rvalid", bus.cpu_rvalid, 1'b1);
    chk8("t1_c3_rdata", bus.cpu_rdata, 8'hA7);
    chk1("t1_c3_busy", bus.busy, 1'b0);
    chk1("t1_c3_stall", bus.cpu_stall, 1'b0);
    next_cycle(); settle();
    chk1("t1_c4_rvalid", bus.cpu_rvalid, 1'b0);
    chk8("t1_c4_rdata_hold", bus.cpu_rdata, 8'hA7);

    // ---- back-to-back CPU reads 0x00..0x07 ----
    next_cycle();
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h00;
    for (int i = 0; i < 8; i++) begin
      next_cycle(); settle();
      chk1("b2b_gnt", bus.cpu_gnt, 1'b1);
      chk8("b2b_addr", bus.mem_addr, 8'(i));
      chk1("b2b_busy_acc", bus.busy, 1'b1);
      chk1("b2b_rvalid_acc", bus.cpu_rvalid, i > 0);
      if (i > 0) chk8("b2b_rdata", bus.cpu_rdata, 8'h60 + 8'(i - 1));
      next_cycle();
      if (i < 7) bus.cpu_addr = 8'(i + 1);
      else       bus.cpu_req = 1'b0;
      settle();
      chk1("b2b_gnt_data", bus.cpu_gnt, 1'b0);
      chk1("b2b_busy_data", bus.busy, 1'b1);
      chk1("b2b_rvalid_data", bus.cpu_rvalid, 1'b0);
    end
    next_cycle(); settle();
    chk1("b2b_last_rvalid", bus.cpu_rvalid, 1'b1);
    chk8("b2b_last_rdata", bus.cpu_rdata, 8'h67);
    chk1("b2b_idle", bus.busy, 1'b0);

    // ---- simultaneous requests: dbg write 0x3C to 0x02, cpu read 0x02 ----
    next_cycle();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h02; bus.dbg_wdata = 8'h3C;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h02;
    settle();
    chk1("t2_c0_dbg_gnt", bus.dbg_gnt, 1'b0);
    chk1("t2_c0_stall", bus.cpu_stall, 1'b1);
    next_cycle(); settle();
    chk1("t2_c1_dbg_gnt", bus.dbg_gnt, 1'b1);
    chk1("t2_c1_cpu_gnt", bus.cpu_gnt, 1'b0);
    chk1("t2_c1_we", bus.mem_we, 1'b1);
    chk8("t2_c1_addr", bus.mem_addr, 8'h02);
    chk8("t2_c1_wdata", bus.mem_wdata, 8'h3C);
    chk1("t2_c1_stall", bus.cpu_stall, 1'b1);
    next_cycle();
    bus.dbg_req = 1'b0;
    settle();
    chk1("t2_c2_cpu_gnt", bus.cpu_gnt, 1'b0);
    chk1("t2_c2_we", bus.mem_we, 1'b0);
    chk8("t2_c2_addr_hold", bus.mem_addr, 8'h02);
    chk8("t2_c2_wdata_hold", bus.mem_wdata, 8'h3C);
    next_cycle(); settle();
    chk1("t2_c3_cpu_gnt", bus.cpu_gnt, 1'b1);
    chk1("t2_c3_we", bus.mem_we, 1'b0);
    chk1("t2_c3_dbg_rvalid", bus.dbg_rvalid, 1'b0);
    next_cycle();
    bus.cpu_req = 1'b0;
    settle();
    chk1("t2_c4_cpu_gnt", bus.cpu_gnt, 1'b0);
    next_cycle(); settle();
    chk1("t2_c5_rvalid", bus.cpu_rvalid, 1'b1);
    chk8("t2_c5_rdata", bus.cpu_rdata, 8'h3C);
    chk1("t2_c5_dbg_rvalid", bus.dbg_rvalid, 1'b0);

    // ---- continuous dbg with waiting cpu: 4 dbg grants then 1 cpu grant ----
    next_cycle();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h03;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h04;
    for (int i = 0; i < 20; i++) begin
      next_cycle(); settle();
      chk1("hold_dbg_gnt", bus.dbg_gnt, (i % 5) != 4);
      chk1("hold_cpu_gnt", bus.cpu_gnt, (i % 5) == 4);
      if (i > 0) begin
        chk1("hold_dbg_rvalid", bus.dbg_rvalid, ((i - 1) % 5) != 4);
        chk1("hold_cpu_rvalid", bus.cpu_rvalid, ((i - 1) % 5) == 4);
      end
      if (i == 1) chk8("hold_dbg_rdata", bus.dbg_rdata, 8'h63);
      if (i == 5) chk8("hold_cpu_rdata", bus.cpu_rdata, 8'h64);
      next_cycle();
      if (i == 19) begin
        bus.dbg_req = 1'b0;
        bus.cpu_req = 1'b0;
      end
    end
    next_cycle(); settle();
    chk1("hold_idle", bus.busy, 1'b0);
    chk1("hold_last_cpu_rvalid", bus.cpu_rvalid, 1'b1);

    // ---- reset during ACCESS of dbg write 0x55 to 0x10 ----
    next_cycle();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h10; bus.dbg_wdata = 8'h55;
    settle();
    chk1("t4_c0_gnt", bus.dbg_gnt, 1'b0);
    next_cycle();
    rst = 1'b0;
    settle();
    chk1("t4_c1_we", bus.mem_we, 1'b0);
    chk1("t4_c1_gnt", bus.dbg_gnt, 1'b0);
    next_cycle();
    rst = 1'b1;
    bus.dbg_req = 1'b0;
    settle();
    chk1("t4_c2_busy", bus.busy, 1'b0);
    chk1("t4_c2_rvalid", bus.dbg_rvalid, 1'b0);
    chk8("t4_c2_addr", bus.mem_addr, 8'h00);
    chk8("t4_c2_wdata", bus.mem_wdata, 8'h00);
    chk8("t4_c2_ram", ram[8'h10], 8'h99);
    next_cycle(); settle();
    chk1("t4_c3_rvalid", bus.dbg_rvalid, 1'b0);
    chk8("t4_c3_ram", ram[8'h10], 8'h99);

    // ---- reset during DATA of a cpu read: no rvalid ----
    next_cycle();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h15;
    next_cycle(); settle();
    chk1("t6_gnt", bus.cpu_gnt, 1'b1);
    next_cycle();
    bus.cpu_req = 1'b0;
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    settle();
    chk1("t6_rvalid", bus.cpu_rvalid, 1'b0);
    chk8("t6_rdata", bus.cpu_rdata, 8'h00);
    chk1("t6_busy", bus.busy, 1'b0);
    next_cycle(); settle();
    chk1("t6_rvalid_late", bus.cpu_rvalid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
